sevenseg_scan_ctrl: RTL and testbench
=====================================

# sevenseg_scan_ctrl

Sequencing controller for a 3-digit multiplexed seven-segment display. It accepts an 8-bit binary value on a load strobe and converts it to BCD over 8 cycles with a sequential shift-add-3 converter. It then time-multiplexes the digits onto shared segment lines, with inter-digit blanking and optional leading-zero suppression. It sits between the switch/value logic in `top` and the display pins, replacing direct combinational segment drive.

## Interface

Parameters:
- `DIGIT_TICKS`, default 12000: clk cycles each digit is driven (1 ms at 12 MHz); must be ≥1.
- `BLANK_TICKS`, default 120: clk cycles of all-digits-off dead time between digits (anti-ghosting); must be ≥1.

Ports:
- `clk` — input, 1 — system clock (12 MHz on board).
- `rst` — input, 1 — reset, asynchronous, active-high.
- `value_i` — input, 8 — binary value 0..255, sampled on accepted load.
- `load_i` — input, 1 — load strobe; accepted when `load_i && !busy_o`.
- `lz_blank_i` — input, 1 — 1 = suppress leading zeros; sampled each cycle.
- `busy_o` — output, 1 — conversion in progress; loads ignored while high.
- `seg_o` — output, 7 — segments, active-high, bit order {g,f,e,d,c,b,a}.
- `dig_o` — output, 3 — one-hot digit enable, active-high; [0] ones, [1] tens, [2] hundreds.

## Operation

- **Conversion FSM**, states CONV_IDLE and CONV_SHIFT.
  - CONV_IDLE: an accepted load copies `value_i` into the shift register, clears the BCD accumulator and enters CONV_SHIFT.
  - CONV_SHIFT: runs exactly 8 iterations. Each iteration first adds 3 to every BCD nibble ≥5, then shifts left by one, with the binary MSB entering the accumulator.
  - After the 8th iteration the result is written into the `pending` register, the `pending_vld` flag is set, and the FSM returns to CONV_IDLE.
- **Display register**:
  - `pending` is copied to the display register only at the start of a BLANK phase, so there is no mid-digit tearing.
  - A later conversion that completes before that BLANK start overwrites `pending`; last value wins.
- **Scan FSM**, states DIGIT_ON and BLANK, with a 2-bit digit index cycling 0→1→2→0 (index 3 unreachable).
  - DIGIT_ON lasts `DIGIT_TICKS` cycles: `dig_o` = one-hot(index) and `seg_o` = LUT(digit[index]), or 0 if that digit is blanked.
  - BLANK lasts `BLANK_TICKS` cycles with `dig_o`=0 and `seg_o`=0. The index advances on BLANK exit.
- **Leading-zero rule** (only when `lz_blank_i`=1):
  - Hundreds is blanked if it is 0.
  - Tens is blanked if hundreds=0 and tens=0.
  - Ones is never blanked.
  - When blanked, `dig_o` is still driven and `seg_o`=0.
- **Segment LUT**, values 0-9: 3F,06,5B,4F,66,6D,7D,07,7F,6F (hex). BCD digits are always ≤9 by construction.
- **Width rules**:
  - BCD accumulator is 12 bits. Max 255 gives hundreds ≤2, so the upper nibble never overflows.
  - Scan counter width is `$clog2(max(DIGIT_TICKS,BLANK_TICKS))`.

## Timing

- **Reset values**:
  - All outputs: `busy_o`=0, `seg_o`=0, `dig_o`=0.
  - Scan FSM in BLANK with index=0 and counter=0.
  - Display register = 000, `pending_vld`=0.
  - Conversion FSM in CONV_IDLE.
- **Load and busy**:
  - A load accepted at edge N gives `busy_o`=1 for cycles N+1..N+8.
  - `pending` holds the result at N+9 and `busy_o`=0 at N+9.
  - A new load may be accepted at edge N+9.
- **Output latency**: all outputs are registered, and `seg_o`/`dig_o` change on the same edge.
  - The first DIGIT_ON begins `BLANK_TICKS` cycles after reset release.
  - The full refresh period is 3×(`DIGIT_TICKS`+`BLANK_TICKS`) cycles.
- **Simultaneous events**:
  - A load asserted while `busy_o`=1 is dropped, not queued.
  - If conversion completion and BLANK start fall on the same edge, the BLANK start copies the old `pending`; the new value is taken at the next BLANK start.
- **Reset mid-operation**: an in-flight conversion is discarded, the display reverts to 000, and no partial value is ever displayed.

## Structure

- `sevenseg_pkg`: conversion and scan state enums, the `SEG_LUT` constant array (indices 0-9), `SEG_BLANK`=7'h00, and the digit index type.
- Sub-module `bin2bcd_seq`: start/busy/done handshake with `bin[7:0]` in and `bcd[11:0]` out; it contains the conversion FSM.
- The top-level `sevenseg_scan_ctrl` holds the pending/display registers, the scan FSM and the output registers.

## Test plan

Bench uses `DIGIT_TICKS`=4 and `BLANK_TICKS`=1.

- **Reset release, no load, `lz_blank_i`=1**: `seg_o`=0 and `dig_o`=0 during reset and for 1 cycle after. Then the tens and hundreds windows show `seg_o`=00 with the digit enabled, and the ones window shows 3F.
- **Load 255, `lz_blank_i`=0**: `busy_o` high exactly 8 cycles. From the next BLANK start, the ones window shows 6D, tens 6D and hundreds 5B, each for 4 cycles separated by 1-cycle all-zero gaps.
- **Load 100, `lz_blank_i`=1**: ones 3F, tens 3F (not blanked), hundreds 06.
- **Load 7, `lz_blank_i`=1**: ones 07, and the tens/hundreds windows have `seg_o`=00. Toggle `lz_blank_i` to 0: tens and hundreds show 3F from the next DIGIT_ON cycle.
- **Load 35, then strobe load with 99 during busy**: 99 is ignored and the display shows ones 6D, tens 4F. Loading 128 after busy drops gives 7F/5B/06.
- **Assert `rst` 4 cycles into a conversion of 210**: outputs go to 0 asynchronously. After release the display shows 000 (with `lz_blank_i`=1, only the ones window shows 3F), and 210 never appears.

Source files
------------

// File: rtl/sevenseg_pkg.sv
// Shared types, segment table and small helpers for the multiplexed seven-segment controller.
package sevenseg_pkg;

  typedef enum logic {
    ConvIdle,
    ConvShift
  } conv_state_e;

  typedef enum logic {
    ScanBlank,
    ScanDigitOn
  } scan_state_e;

  // Digit index: 0 = ones, 1 = tens, 2 = hundreds; 3 is never reached.
  typedef logic [1:0] dig_idx_t;

  localparam int unsigned BinW = 8;
  localparam int unsigned BcdW = 12;
  localparam int unsigned IterW = 3;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Segment patterns {g,f,e,d,c,b,a} for digits 0..9, index 0 at the LSB end.
  localparam logic [9:0][6:0] SEG_LUT = {
    7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  // Non-decimal codes cannot come out of the converter; they map to dark anyway.
  function automatic logic [6:0] seg_encode(input logic [3:0] bcd);
    logic [6:0] seg;
    seg = SEG_BLANK;
    if (bcd <= 4'd9) begin
      seg = SEG_LUT[bcd];
    end
    return seg;
  endfunction

  function automatic logic [2:0] dig_onehot(input dig_idx_t idx);
    logic [2:0] oh;
    oh = 3'b000;
    unique case (idx)
      2'd0:    oh = 3'b001;
      2'd1:    oh = 3'b010;
      2'd2:    oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

  // Shift-add-3 correction for one BCD nibble.
  function automatic logic [3:0] add3(input logic [3:0] nib);
    logic [3:0] res;
    res = nib;
    if (nib >= 4'd5) begin
      res = nib + 4'd3;
    end
    return res;
  endfunction

endpackage

// File: rtl/sevenseg_scan_ctrl_bin2bcd.sv
// Sequential 8-bit binary to 3-digit BCD converter (shift-add-3, one bit per cycle).
module bin2bcd_seq
  import sevenseg_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [BinW-1:0] bin_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [BcdW-1:0] bcd_o
);

  conv_state_e      state_q, state_d;
  logic [BinW-1:0]  sr_q, sr_d;
  logic [BcdW-1:0]  acc_q, acc_d;
  logic [BcdW-1:0]  adj;
  logic [IterW-1:0] iter_q, iter_d;

  // Add-3 correction of every nibble ahead of this cycle's shift.
  always_comb begin
    adj = {add3(acc_q[11:8]), add3(acc_q[7:4]), add3(acc_q[3:0])};
  end

  // Conversion FSM next state; done fires on the edge of the 8th shift.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    acc_d   = acc_q;
    iter_d  = iter_q;
    done_o  = 1'b0;
    unique case (state_q)
      ConvIdle: begin
        if (start_i) begin
          state_d = ConvShift;
          sr_d    = bin_i;
          acc_d   = '0;
          iter_d  = '0;
        end
      end
      ConvShift: begin
        acc_d  = {adj[BcdW-2:0], sr_q[BinW-1]};
        sr_d   = {sr_q[BinW-2:0], 1'b0};
        iter_d = iter_q + IterW'(1);
        if (iter_q == IterW'(BinW - 1)) begin
          state_d = ConvIdle;
          done_o  = 1'b1;
        end
      end
      default: state_d = ConvIdle;
    endcase
  end

  // Conversion state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ConvIdle;
      sr_q    <= '0;
      acc_q   <= '0;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      acc_q   <= acc_d;
      iter_q  <= iter_d;
    end
  end

  assign busy_o = (state_q == ConvShift);
  // Valid only while done_o is high: the fully shifted result.
  assign bcd_o  = acc_d;

endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// Three-digit seven-segment scan controller: BCD conversion, tear-free display update,
// digit multiplexing with dead time, and optional leading-zero suppression.
module sevenseg_scan_ctrl
  import sevenseg_pkg::*;
#(
  parameter int unsigned DIGIT_TICKS = 12000,
  parameter int unsigned BLANK_TICKS = 120
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] value_i,
  input  logic       load_i,
  input  logic       lz_blank_i,
  output logic       busy_o,
  output logic [6:0] seg_o,
  output logic [2:0] dig_o
);

  localparam int unsigned MaxTicks  = (DIGIT_TICKS > BLANK_TICKS) ? DIGIT_TICKS : BLANK_TICKS;
  localparam int unsigned CntW      = (MaxTicks > 1) ? $clog2(MaxTicks) : 1;
  localparam logic [CntW-1:0] DigitLast = CntW'(DIGIT_TICKS - 1);
  localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_TICKS - 1);

  logic            conv_busy;
  logic            conv_done;
  logic [BcdW-1:0] conv_bcd;

  logic [BcdW-1:0] pending_q, pending_d;
  logic            pending_vld_q, pending_vld_d;
  logic [BcdW-1:0] disp_q, disp_d;
  scan_state_e     scan_q, scan_d;
  dig_idx_t        idx_q, idx_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            blank_start;
  logic [6:0]      seg_q, seg_d;
  logic [2:0]      dig_q, dig_d;
  logic [3:0]      cur_digit;
  logic            cur_blanked;

  bin2bcd_seq u_bin2bcd (
    .clk     (clk),
    .rst     (rst),
    .start_i (load_i && !conv_busy),
    .bin_i   (value_i),
    .busy_o  (conv_busy),
    .done_o  (conv_done),
    .bcd_o   (conv_bcd)
  );

  // Scan FSM: DIGIT_ON/BLANK timing; the digit index advances as BLANK ends.
  always_comb begin
    scan_d      = scan_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q + CntW'(1);
    blank_start = 1'b0;
    unique case (scan_q)
      ScanBlank: begin
        if (cnt_q == BlankLast) begin
          scan_d = ScanDigitOn;
          cnt_d  = '0;
          idx_d  = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
        end
      end
      ScanDigitOn: begin
        if (cnt_q == DigitLast) begin
          scan_d      = ScanBlank;
          cnt_d       = '0;
          blank_start = 1'b1;
        end
      end
      default: begin
        scan_d = ScanBlank;
        cnt_d  = '0;
      end
    endcase
  end

  // Pending/display handoff. The BLANK start consumes the old pending value even when a
  // conversion finishes on the same edge; the new result then waits for the next BLANK.
  always_comb begin
    pending_d     = pending_q;
    pending_vld_d = pending_vld_q;
    disp_d        = disp_q;
    if (blank_start && pending_vld_q) begin
      disp_d        = pending_q;
      pending_vld_d = 1'b0;
    end
    if (conv_done) begin
      pending_d     = conv_bcd;
      pending_vld_d = 1'b1;
    end
  end

  // Digit selection and leading-zero suppression for the upcoming scan slot.
  always_comb begin
    cur_digit   = 4'd0;
    cur_blanked = 1'b0;
    unique case (idx_d)
      2'd0: cur_digit = disp_q[3:0];
      2'd1: begin
        cur_digit   = disp_q[7:4];
        cur_blanked = lz_blank_i && (disp_q[11:8] == 4'd0) && (disp_q[7:4] == 4'd0);
      end
      2'd2: begin
        cur_digit   = disp_q[11:8];
        cur_blanked = lz_blank_i && (disp_q[11:8] == 4'd0);
      end
      default: cur_blanked = 1'b1;
    endcase
  end

  // Output next values follow the next scan state so seg/dig switch on the same edge.
  always_comb begin
    seg_d = SEG_BLANK;
    dig_d = 3'b000;
    if (scan_d == ScanDigitOn) begin
      dig_d = dig_onehot(idx_d);
      seg_d = cur_blanked ? SEG_BLANK : seg_encode(cur_digit);
    end
  end

  // Scan, display and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q     <= '0;
      pending_vld_q <= 1'b0;
      disp_q        <= '0;
      scan_q        <= ScanBlank;
      idx_q         <= 2'd0;
      cnt_q         <= '0;
      seg_q         <= SEG_BLANK;
      dig_q         <= 3'b000;
    end else begin
      pending_q     <= pending_d;
      pending_vld_q <= pending_vld_d;
      disp_q        <= disp_d;
      scan_q        <= scan_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      seg_q         <= seg_d;
      dig_q         <= dig_d;
    end
  end

  assign busy_o = conv_busy;
  assign seg_o  = seg_q;
  assign dig_o  = dig_q;

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Directed, table-driven bench for sevenseg_scan_ctrl with DIGIT_TICKS=4, BLANK_TICKS=1.
module tb_sevenseg_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] value_i;
  logic       load_i;
  logic       lz_blank_i;
  logic       busy_o;
  logic [6:0] seg_o;
  logic [2:0] dig_o;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [7:0] value;
    logic       lz;
    logic       inject;
    logic [6:0] ones;
    logic [6:0] tens;
    logic [6:0] hund;
  } vec_t;

  vec_t vecs [9];

  sevenseg_scan_ctrl #(
    .DIGIT_TICKS (4),
    .BLANK_TICKS (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .value_i    (value_i),
    .load_i     (load_i),
    .lz_blank_i (lz_blank_i),
    .busy_o     (busy_o),
    .seg_o      (seg_o),
    .dig_o      (dig_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Waits (sampling at negedges) until dig_o changes into the value 'to'.
  task automatic wait_entry(input string name, input logic [2:0] to);
    logic [2:0] prev;
    bit         found;
    int         n;
    prev  = dig_o;
    found = 1'b0;
    n     = 0;
    while (!found && n < 100) begin
      @(negedge clk);
      n++;
      found = (prev != to) && (dig_o == to);
      prev  = dig_o;
    end
    if (!found) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s: no dig_o entry to %b within 100 cycles (got %b)", name, to, dig_o);
    end
  endtask

  // Captures one full refresh starting at a BLANK start: 1 gap + 4 on, three times.
  task automatic capture(input string name, input logic [6:0] e_ones, input logic [6:0] e_tens,
                         input logic [6:0] e_hund);
    logic [6:0] segs [3];
    int         lens [3];
    int         bad;
    int         i;
    wait_entry({name, "_sync"}, 3'b000);
    for (int j = 0; j < 3; j++) begin
      segs[j] = 7'h00;
      lens[j] = 0;
    end
    bad = 0;
    for (int k = 0; k < 15; k++) begin
      if (k > 0) @(negedge clk);
      if (k % 5 == 0) begin
        if (dig_o != 3'b000 || seg_o != 7'h00) bad++;
      end else begin
        case (dig_o)
          3'b001:  i = 0;
          3'b010:  i = 1;
          3'b100:  i = 2;
          default: i = -1;
        endcase
        if (i < 0) begin
          bad++;
        end else begin
          if (lens[i] == 0) segs[i] = seg_o;
          else if (segs[i] != seg_o) bad++;
          lens[i]++;
        end
      end
    end
    check({name, "_ones"}, segs[0], e_ones);
    check({name, "_tens"}, segs[1], e_tens);
    check({name, "_hund"}, segs[2], e_hund);
    check({name, "_winlen"}, {lens[2][7:0], lens[1][7:0], lens[0][7:0]}, 24'h040404);
    check({name, "_shape"}, bad, 0);
  endtask

  // Issues one load; optionally strobes a second load (99) while busy.
  task automatic do_load(input string name, input logic [7:0] v, input logic inject);
    int n;
    @(negedge clk);
    value_i = v;
    load_i  = 1'b1;
    @(negedge clk);
    load_i = 1'b0;
    n = 0;
    while (busy_o && n < 50) begin
      n++;
      if (inject && n == 3) begin
        value_i = 8'd99;
        load_i  = 1'b1;
      end else begin
        load_i = 1'b0;
      end
      @(negedge clk);
    end
    load_i = 1'b0;
    check({name, "_busy_len"}, n, 8);
  endtask

  initial begin
    vecs[0] = '{8'd255, 1'b0, 1'b0, 7'h6D, 7'h6D, 7'h5B};
    vecs[1] = '{8'd100, 1'b1, 1'b0, 7'h3F, 7'h3F, 7'h06};
    vecs[2] = '{8'd7,   1'b1, 1'b0, 7'h07, 7'h00, 7'h00};
    vecs[3] = '{8'd35,  1'b1, 1'b1, 7'h6D, 7'h4F, 7'h00};
    vecs[4] = '{8'd128, 1'b0, 1'b0, 7'h7F, 7'h5B, 7'h06};
    vecs[5] = '{8'd0,   1'b0, 1'b0, 7'h3F, 7'h3F, 7'h3F};
    vecs[6] = '{8'd50,  1'b1, 1'b0, 7'h3F, 7'h6D, 7'h00};
    vecs[7] = '{8'd42,  1'b0, 1'b0, 7'h5B, 7'h66, 7'h3F};
    vecs[8] = '{8'd9,   1'b1, 1'b0, 7'h6F, 7'h00, 7'h00};

    rst        = 1'b1;
    load_i     = 1'b0;
    value_i    = 8'd0;
    lz_blank_i = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", busy_o, 1'b0);
    check("rst_seg", seg_o, 7'h00);
    check("rst_dig", dig_o, 3'b000);

    // Reset release: one dark cycle, then the tens slot (display 000, suppressed).
    rst = 1'b0;
    @(negedge clk);
    check("first_dig", dig_o, 3'b010);
    check("first_seg", seg_o, 7'h00);
    capture("post_reset", 7'h3F, 7'h00, 7'h00);

    for (int v = 0; v < 9; v++) begin
      lz_blank_i = vecs[v].lz;
      do_load($sformatf("vec%0d", v), vecs[v].value, vecs[v].inject);
      capture($sformatf("vec%0d", v), vecs[v].ones, vecs[v].tens, vecs[v].hund);
    end

    // Leading-zero enable dropped mid tens window: segments light on the next cycle.
    lz_blank_i = 1'b1;
    do_load("ld7", 8'd7, 1'b0);
    capture("ld7", 7'h07, 7'h00, 7'h00);
    wait_entry("tens_entry", 3'b010);
    check("lz_on_tens", seg_o, 7'h00);
    lz_blank_i = 1'b0;
    @(negedge clk);
    check("lz_off_dig", dig_o, 3'b010);
    check("lz_off_tens", seg_o, 7'h3F);
    capture("lz_off", 7'h07, 7'h3F, 7'h3F);

    // Reset four cycles into a conversion of 210: nothing of it may survive.
    @(negedge clk);
    value_i = 8'd210;
    load_i  = 1'b1;
    @(negedge clk);
    load_i = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_busy", busy_o, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("async_busy", busy_o, 1'b0);
    check("async_seg", seg_o, 7'h00);
    check("async_dig", dig_o, 3'b000);
    @(negedge clk);
    @(negedge clk);
    rst        = 1'b0;
    lz_blank_i = 1'b1;
    capture("after_rst_a", 7'h3F, 7'h00, 7'h00);
    capture("after_rst_b", 7'h3F, 7'h00, 7'h00);
    check("after_rst_busy", busy_o, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
